// File: rtl/kamus_pkg.sv
// kamus_pkg: shared core widths and register-address type
package kamus_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/kamus_regfile_if.sv
// kamus_regfile_if: WB write, ID read/issue and flush signals of the register file
interface kamus_regfile_if #(parameter int XLEN = kamus_pkg::XLEN);
  import kamus_pkg::*;
  logic regfile_wr_en;
  reg_addr_t rd_addr;
  logic [XLEN-1:0] wb_data;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic iss_valid;
  reg_addr_t iss_rd_addr;
  logic flush;
  logic rs1_busy;
  logic rs2_busy;
  modport master (
    output regfile_wr_en, rd_addr, wb_data, rs1_addr, rs2_addr, iss_valid, iss_rd_addr, flush,
    input rs1_data, rs2_data, rs1_busy, rs2_busy
  );
  modport slave (
    input regfile_wr_en, rd_addr, wb_data, rs1_addr, rs2_addr, iss_valid, iss_rd_addr, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/kamus_scoreboard.sv
// kamus_scoreboard: pending-write bit per register with set/clear/flush and busy lookups
module kamus_scoreboard import kamus_pkg::*; #(
  parameter int NUM_REGS = kamus_pkg::NUM_REGS
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  logic      iss_valid,
  input  reg_addr_t iss_addr,
  input  logic      flush,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy
);
  localparam int SPAN = 2 ** REG_ADDR_W;
  logic [NUM_REGS-1:0] pend, pend_nxt;
  logic [SPAN-1:0] pend_ext;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pend <= '0;
    else pend <= pend_nxt;
  // a new issue outranks a retiring write to the same rd; x0 never pends
  always_comb begin
    pend_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++)
      pend_nxt[i] = flush ? 1'b0 :
                    (iss_valid && iss_addr == reg_addr_t'(i)) ? 1'b1 :
                    (wr_en && wr_addr == reg_addr_t'(i)) ? 1'b0 : pend[i];
  end
  assign pend_ext = SPAN'(pend);
  assign rs1_busy = pend_ext[rs1_addr] & ~(wr_en && wr_addr == rs1_addr);
  assign rs2_busy = pend_ext[rs2_addr] & ~(wr_en && wr_addr == rs2_addr);
endmodule

// File: rtl/kamus_regfile.sv
// kamus_regfile: integer register file with WB bypass and RAW scoreboard
module kamus_regfile import kamus_pkg::*; #(
  parameter int XLEN = kamus_pkg::XLEN,
  parameter int NUM_REGS = kamus_pkg::NUM_REGS
) (
  input logic clk_i,
  input logic rst_i,
  kamus_regfile_if.slave bus
);
  logic [XLEN-1:0] regs [NUM_REGS];
  logic wr_ok, rs1_zero, rs2_zero;
  assign wr_ok = bus.regfile_wr_en && bus.rd_addr != '0 && 32'(bus.rd_addr) < NUM_REGS;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) regs <= '{default: '0};
    else if (wr_ok) regs[bus.rd_addr] <= bus.wb_data;
  // reads are forced to zero during reset so the bypass cannot leak wb_data
  assign rs1_zero = rst_i || bus.rs1_addr == '0 || 32'(bus.rs1_addr) >= NUM_REGS;
  assign rs2_zero = rst_i || bus.rs2_addr == '0 || 32'(bus.rs2_addr) >= NUM_REGS;
  assign bus.rs1_data = rs1_zero ? '0 :
                        (bus.regfile_wr_en && bus.rd_addr == bus.rs1_addr) ? bus.wb_data : regs[bus.rs1_addr];
  assign bus.rs2_data = rs2_zero ? '0 :
                        (bus.regfile_wr_en && bus.rd_addr == bus.rs2_addr) ? bus.wb_data : regs[bus.rs2_addr];
  kamus_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en    (bus.regfile_wr_en),
    .wr_addr  (bus.rd_addr),
    .iss_valid(bus.iss_valid),
    .iss_addr (bus.iss_rd_addr),
    .flush    (bus.flush),
    .rs1_addr (bus.rs1_addr),
    .rs2_addr (bus.rs2_addr),
    .rs1_busy (bus.rs1_busy),
    .rs2_busy (bus.rs2_busy)
  );
endmodule

// File: tb/tb_kamus_regfile.sv
// tb_kamus_regfile: directed and random checks of kamus_regfile against an array model
module tb_kamus_regfile;
  import kamus_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;
  kamus_regfile_if bus();
  kamus_regfile dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [31:0] m_regs [32];
  logic m_pend [32];
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask
  function automatic logic [31:0] exp_data(int a);
    if (a == 0) return '0;
    if (bus.regfile_wr_en && int'(bus.rd_addr) == a) return bus.wb_data;
    return m_regs[a];
  endfunction
  function automatic logic [31:0] exp_busy(int a);
    return {31'b0, m_pend[a] && !(bus.regfile_wr_en && int'(bus.rd_addr) == a)};
  endfunction
  task automatic drive(logic wr, int rd, logic [31:0] wd, int r1, int r2, logic iv, int ird, logic fl);
    bus.regfile_wr_en = wr;
    bus.rd_addr = 5'(rd);
    bus.wb_data = wd;
    bus.rs1_addr = 5'(r1);
    bus.rs2_addr = 5'(r2);
    bus.iss_valid = iv;
    bus.iss_rd_addr = 5'(ird);
    bus.flush = fl;
    #1;
    chk($sformatf("rs1_data x%0d", r1), bus.rs1_data, exp_data(r1));
    chk($sformatf("rs2_data x%0d", r2), bus.rs2_data, exp_data(r2));
    chk($sformatf("rs1_busy x%0d", r1), 32'(bus.rs1_busy), exp_busy(r1));
    chk($sformatf("rs2_busy x%0d", r2), 32'(bus.rs2_busy), exp_busy(r2));
  endtask
  task automatic tick();
    @(posedge clk_i);
    if (bus.regfile_wr_en && bus.rd_addr != 0) m_regs[bus.rd_addr] = bus.wb_data;
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else begin
      if (bus.regfile_wr_en && bus.rd_addr != 0) m_pend[bus.rd_addr] = 1'b0;
      if (bus.iss_valid && bus.iss_rd_addr != 0) m_pend[bus.iss_rd_addr] = 1'b1;
    end
    @(negedge clk_i);
  endtask
  initial begin
    model_reset();
    bus.regfile_wr_en = 1'b1;
    bus.rd_addr = 5'd5;
    bus.wb_data = 32'hCAFEF00D;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd7;
    bus.iss_valid = 1'b1;
    bus.iss_rd_addr = 5'd7;
    bus.flush = 1'b0;
    @(negedge clk_i);
    #1;
    chk("reset rs1_data bypass blocked", bus.rs1_data, 32'h0);
    chk("reset rs2_busy", 32'(bus.rs2_busy), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 0, 0, 5, 7, 0, 0, 0);
    chk("no write during reset", bus.rs1_data, 32'h0);
    tick();
    drive(1, 5, 32'hDEADBEEF, 5, 7, 1, 7, 0);
    tick();
    drive(0, 0, 0, 5, 7, 0, 0, 0);
    chk("x5 written", bus.rs1_data, 32'hDEADBEEF);
    chk("x7 pending", 32'(bus.rs2_busy), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("async rst x5 data", bus.rs1_data, 32'h0);
    chk("async rst x7 busy", 32'(bus.rs2_busy), 32'h0);
    rst_i = 1'b0;
    model_reset();
    tick();
    drive(1, 3, 32'h12345678, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 32'hFFFFFFFF, 3, 0, 0, 0, 0);
    chk("x3 read", bus.rs1_data, 32'h12345678);
    chk("x0 bypass ignored", bus.rs2_data, 32'h0);
    tick();
    drive(0, 0, 0, 0, 3, 0, 0, 0);
    chk("x0 stays zero", bus.rs1_data, 32'h0);
    drive(0, 0, 0, 0, 0, 1, 9, 0);
    tick();
    drive(1, 9, 32'hA5A5A5A5, 0, 9, 0, 0, 0);
    chk("bypass x9 data", bus.rs2_data, 32'hA5A5A5A5);
    chk("bypass x9 busy", 32'(bus.rs2_busy), 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 4, 0);
    tick();
    drive(0, 0, 0, 4, 0, 0, 0, 0);
    chk("x4 busy after issue", 32'(bus.rs1_busy), 32'h1);
    drive(1, 4, 32'h10, 4, 0, 0, 0, 0);
    chk("x4 busy during wb", 32'(bus.rs1_busy), 32'h0);
    chk("x4 bypass", bus.rs1_data, 32'h10);
    tick();
    drive(0, 0, 0, 4, 0, 0, 0, 0);
    chk("x4 busy after wb", 32'(bus.rs1_busy), 32'h0);
    chk("x4 data after wb", bus.rs1_data, 32'h10);
    drive(0, 0, 0, 0, 0, 1, 6, 0);
    tick();
    drive(1, 6, 32'h55, 6, 0, 1, 6, 0);
    chk("collision same-cycle busy", 32'(bus.rs1_busy), 32'h0);
    tick();
    drive(0, 0, 0, 6, 0, 0, 0, 0);
    chk("collision set wins", 32'(bus.rs1_busy), 32'h1);
    chk("collision data", bus.rs1_data, 32'h55);
    drive(1, 6, 32'h66, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 2, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 8, 0);
    tick();
    drive(0, 0, 0, 2, 8, 1, 11, 1);
    chk("pre-flush x2 busy", 32'(bus.rs1_busy), 32'h1);
    chk("pre-flush x8 busy", 32'(bus.rs2_busy), 32'h1);
    tick();
    drive(0, 0, 0, 2, 11, 0, 0, 0);
    chk("flush x2", 32'(bus.rs1_busy), 32'h0);
    chk("flush beats issue x11", 32'(bus.rs2_busy), 32'h0);
    drive(0, 0, 0, 8, 6, 0, 0, 0);
    chk("flush x8", 32'(bus.rs1_busy), 32'h0);
    tick();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
            $urandom_range(0, 15), $urandom_range(0, 31),
            1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
